fp4_fft_agu: RTL

FP4_FFT_AGU -- requirements
Module: fp4_fft_agu

---
 rtl/fp4_fft_agu.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/fp4_fft_agu.sv
// Address generator for a 32-point radix-2 FFT: bit-reversed load into bank 0,
// then five ping-pong butterfly stages with a BF_LAT-deep write-back delay line.
module fp4_fft_agu #(
    parameter int BF_LAT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic [7:0] bf_out_0,
    input  logic [7:0] bf_out_1,
    output logic [4:0] rd_addr_0,
    output logic [4:0] rd_addr_1,
    output logic       wr_en_0,
    output logic       wr_en_1,
    output logic [4:0] wr_addr_0,
    output logic [4:0] wr_addr_1,
    output logic [7:0] wr_data_0,
    output logic [7:0] wr_data_1,
    output logic       bank_sel,
    output logic [3:0] tw_addr,
    output logic       bf_valid,
    output logic [2:0] stage,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_COMPUTE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [4:0] LAST_CYC = 5'(15 + BF_LAT);

    function automatic logic [4:0] bitrev5(input logic [4:0] v);
        bitrev5 = {v[0], v[1], v[2], v[3], v[4]};
    endfunction

    // Top index: k's upper bits moved up one place above the half-size offset.
    function automatic logic [4:0] bf_top(input logic [3:0] k, input logic [2:0] s);
        logic [4:0] k5;
        logic [4:0] mask;
        k5      = {1'b0, k};
        mask    = (5'd1 << s) - 5'd1;
        bf_top  = ((k5 >> s) << (s + 3'd1)) | (k5 & mask);
    endfunction

    function automatic logic [3:0] bf_tw(input logic [3:0] k, input logic [2:0] s);
        logic [3:0] mask;
        mask  = (4'd1 << s) - 4'd1;
        bf_tw = (k & mask) << (3'd4 - s);
    endfunction

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [4:0]  cyc_q, cyc_d;
    logic [2:0]  stage_q, stage_d;
    logic        bank_q, bank_d;
    logic        in_ready_q, in_ready_d;
    logic        busy_q, done_q;
    logic        rd_en_q, rd_en_d;
    logic [4:0]  rd_addr_0_q, rd_addr_0_d;
    logic [4:0]  rd_addr_1_q, rd_addr_1_d;
    logic        bf_valid_q;
    logic [3:0]  tw_q, tw_d;
    logic [7:0]  ld_data_q, ld_data_d;
    logic        accept_s;
    logic [11:0] dl_in_s;
    logic [11:0] ld_entry_s;
    // Delay-line entry: {we1, we0, addr1, addr0}; the last tap drives the write port.
    logic [11:0] dl_q [BF_LAT];

    // Next-state and next-output computation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cyc_d      = cyc_q;
        stage_d    = stage_q;
        bank_d     = bank_q;
        in_ready_d = in_ready_q;
        accept_s   = (state_q == S_LOAD) && in_ready_q && in_valid;
        case (state_q)
            S_IDLE: begin
                bank_d = 1'b0;
                if (start) begin
                    state_d    = S_LOAD;
                    in_ready_d = 1'b1;
                    cnt_d      = 5'd0;
                end else begin
                    in_ready_d = 1'b0;
                end
            end
            S_LOAD: begin
                if (accept_s) begin
                    cnt_d      = cnt_q + 5'd1;
                    in_ready_d = (cnt_q != 5'd31);
                end else if (!in_ready_q) begin
                    state_d = S_COMPUTE;
                    stage_d = 3'd0;
                    cyc_d   = 5'd0;
                    bank_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_COMPUTE: begin
                if (cyc_q == LAST_CYC) begin
                    cyc_d = 5'd0;
                    if (stage_q == 3'd4) begin
                        state_d = S_DONE;
                        stage_d = 3'd0;
                        bank_d  = 1'b0;
                    end else begin
                        stage_d = stage_q + 3'd1;
                        bank_d  = ~bank_q;
                    end
                end else begin
                    cyc_d = cyc_q + 5'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        rd_en_d = (state_d == S_COMPUTE) && (cyc_d < 5'd16);
        if (rd_en_d) begin
            rd_addr_0_d = bf_top(cyc_d[3:0], stage_d);
            rd_addr_1_d = bf_top(cyc_d[3:0], stage_d) + (5'd1 << stage_d);
        end else begin
            rd_addr_0_d = 5'd0;
            rd_addr_1_d = 5'd0;
        end

        if (rd_en_q) begin
            tw_d = bf_tw(cyc_q[3:0], stage_q);
        end else begin
            tw_d = 4'd0;
        end

        if (accept_s) begin
            ld_entry_s = {1'b0, 1'b1, 5'd0, bitrev5(cnt_q)};
            ld_data_d  = in_data;
        end else begin
            ld_entry_s = 12'd0;
            ld_data_d  = 8'd0;
        end

        dl_in_s = {rd_en_q, rd_en_q, rd_addr_1_q, rd_addr_0_q};
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 5'd0;
            cyc_q       <= 5'd0;
            stage_q     <= 3'd0;
            bank_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_0_q <= 5'd0;
            rd_addr_1_q <= 5'd0;
            bf_valid_q  <= 1'b0;
            tw_q        <= 4'd0;
            ld_data_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cyc_q       <= cyc_d;
            stage_q     <= stage_d;
            bank_q      <= bank_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_DONE);
            rd_en_q     <= rd_en_d;
            rd_addr_0_q <= rd_addr_0_d;
            rd_addr_1_q <= rd_addr_1_d;
            bf_valid_q  <= rd_en_q;
            tw_q        <= tw_d;
            ld_data_q   <= ld_data_d;
        end
    end

    // Write-back delay line; load writes are injected straight into the last tap.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BF_LAT; i++) begin
                dl_q[i] <= 12'd0;
            end
        end else begin
            for (int i = BF_LAT - 1; i > 0; i--) begin
                dl_q[i] <= dl_q[i-1];
            end
            dl_q[0] <= dl_in_s;
            if (state_q == S_LOAD) begin
                dl_q[BF_LAT-1] <= ld_entry_s;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign rd_addr_0 = rd_addr_0_q;
    assign rd_addr_1 = rd_addr_1_q;
    assign wr_en_1   = dl_q[BF_LAT-1][11];
    assign wr_en_0   = dl_q[BF_LAT-1][10];
    assign wr_addr_1 = dl_q[BF_LAT-1][9:5];
    assign wr_addr_0 = dl_q[BF_LAT-1][4:0];
    // Port 1 only writes during compute, so it selects butterfly data for both ports.
    assign wr_data_0 = wr_en_1 ? bf_out_0 : ld_data_q;
    assign wr_data_1 = wr_en_1 ? bf_out_1 : 8'd0;
    assign bank_sel  = bank_q;
    assign tw_addr   = tw_q;
    assign bf_valid  = bf_valid_q;
    assign stage     = stage_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
